// File: rtl/stream_load_sequencer.sv
// -----------------------------------------------------------------------------
// stream_load_sequencer
//
// Sequences the weight/feature stream source for one layer. The weight phase
// runs first, then the feature phase. The block drives the source's phase
// select and its one-cycle read kicks. It counts accepted beats on the shared
// stream against the totals latched at start, and it reports completion or a
// stalled stream.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   start             begin a layer load (only honoured in IDLE)
//   clear_err         leave the error state
//   cfg_weight_num    weight beats for this layer (latched at start)
//   cfg_feature_num   feature beats for this layer (latched at start)
//   en                phase select to the source: 1 = weight, 0 = feature
//   dma_read_para     one-cycle weight-read kick
//   dma_read_feature  one-cycle feature-read kick
//   s_valid, s_ready  monitored stream handshake (beat = s_valid & s_ready)
//   busy              layer in progress (start accepted until DONE/ERR)
//   done              one-cycle pulse when both phases are complete
//   err               level; watchdog expired inside a stream phase
//   weight_cnt        weight beats accepted this layer
//   feature_cnt       feature beats accepted this layer
//
// Every output is a register. The kick and done pulses are registered from
// the current state. A start sampled in cycle t therefore enters W_KICK in
// t+1, and dma_read_para is high in t+2. The phase select en is registered
// from the next state. This makes en fall one cycle before the feature kick
// reaches the source.
// -----------------------------------------------------------------------------
module stream_load_sequencer #(
    parameter int WEIGHT_CNT_W   = 19,
    parameter int FEATURE_CNT_W  = 21,
    parameter int SWITCH_GAP     = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     clear_err,
    input  logic [WEIGHT_CNT_W-1:0]  cfg_weight_num,
    input  logic [FEATURE_CNT_W-1:0] cfg_feature_num,
    output logic                     en,
    output logic                     dma_read_para,
    output logic                     dma_read_feature,
    input  logic                     s_valid,
    input  logic                     s_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [WEIGHT_CNT_W-1:0]  weight_cnt,
    output logic [FEATURE_CNT_W-1:0] feature_cnt
);

    // Gap counter runs 0 .. SWITCH_GAP-1 while in SWITCH.
    localparam int GAP_W = (SWITCH_GAP > 1) ? $clog2(SWITCH_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SWITCH_GAP - 1);

    // The watchdog fires when it has already counted TIMEOUT_CYCLES-1 idle
    // cycles and the current cycle is also idle.
    localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_KICK,
        S_W_STREAM,
        S_SWITCH,
        S_F_KICK,
        S_F_STREAM,
        S_DONE,
        S_ERR
    } state_t;

    state_t r_state;
    state_t w_nxt;

    // Configuration latched at start; later cfg changes are not seen.
    logic [WEIGHT_CNT_W-1:0]  r_weight_num;
    logic [FEATURE_CNT_W-1:0] r_feature_num;

    logic [WEIGHT_CNT_W-1:0]  r_weight_cnt;
    logic [FEATURE_CNT_W-1:0] r_feature_cnt;
    logic [GAP_W-1:0]         r_gap;
    logic [TO_W-1:0]          r_wd;

    logic r_en;
    logic r_para;
    logic r_feat;
    logic r_busy;
    logic r_done;
    logic r_err;

    logic                     w_beat;
    logic                     w_in_stream;
    logic [WEIGHT_CNT_W-1:0]  w_weight_inc;
    logic [FEATURE_CNT_W-1:0] w_feature_inc;
    logic                     w_weight_last;
    logic                     w_feature_last;
    logic                     w_wd_expire;
    logic                     w_start_ok;

    logic w_en_nxt;
    logic w_para_nxt;
    logic w_feat_nxt;
    logic w_busy_nxt;
    logic w_done_nxt;
    logic w_err_nxt;

    assign w_beat        = s_valid & s_ready;
    assign w_in_stream   = (r_state == S_W_STREAM) || (r_state == S_F_STREAM);
    assign w_weight_inc  = r_weight_cnt + 1'b1;
    assign w_feature_inc = r_feature_cnt + 1'b1;

    // The current beat is the final one of its phase. The counter is always
    // below the latched total while streaming, so the increment cannot wrap.
    assign w_weight_last  = (w_weight_inc == r_weight_num);
    assign w_feature_last = (w_feature_inc == r_feature_num);

    assign w_wd_expire = WD_EN && w_in_stream && !w_beat && (r_wd == TO_LAST);
    assign w_start_ok  = (r_state == S_IDLE) && start;

    // ---------------------------------------------------------------------
    // Next-state and next-output decode
    // ---------------------------------------------------------------------
    always_comb begin
        w_nxt = r_state;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_weight_num != '0) begin
                        w_nxt = S_W_KICK;
                    end else if (cfg_feature_num != '0) begin
                        w_nxt = S_SWITCH;
                    end else begin
                        w_nxt = S_DONE;
                    end
                end
            end
            S_W_KICK: begin
                w_nxt = S_W_STREAM;
            end
            S_W_STREAM: begin
                if (w_beat && w_weight_last) begin
                    w_nxt = (r_feature_num == '0) ? S_DONE : S_SWITCH;
                end else if (w_wd_expire) begin
                    w_nxt = S_ERR;
                end
            end
            S_SWITCH: begin
                if (r_gap == GAP_LAST) begin
                    w_nxt = S_F_KICK;
                end
            end
            S_F_KICK: begin
                w_nxt = S_F_STREAM;
            end
            S_F_STREAM: begin
                if (w_beat && w_feature_last) begin
                    w_nxt = S_DONE;
                end else if (w_wd_expire) begin
                    w_nxt = S_ERR;
                end
            end
            S_DONE: begin
                w_nxt = S_IDLE;
            end
            S_ERR: begin
                if (clear_err) begin
                    w_nxt = S_IDLE;
                end
            end
            default: begin
                w_nxt = S_IDLE;
            end
        endcase

        // The source sees feature select from the first F_KICK cycle onward.
        w_en_nxt   = !((w_nxt == S_F_KICK) || (w_nxt == S_F_STREAM));
        w_para_nxt = (r_state == S_W_KICK);
        w_feat_nxt = (r_state == S_F_KICK);
        w_done_nxt = (r_state == S_DONE);
        w_err_nxt  = (w_nxt == S_ERR);

        // busy drops together with the done pulse or on entry to ERR.
        w_busy_nxt = r_busy;
        if (w_start_ok) begin
            w_busy_nxt = 1'b1;
        end else if ((r_state == S_DONE) || (w_nxt == S_ERR)) begin
            w_busy_nxt = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // State, counters and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_weight_cnt  <= '0;
            r_feature_cnt <= '0;
            r_gap         <= '0;
            r_wd          <= '0;
            r_en          <= 1'b1;
            r_para        <= 1'b0;
            r_feat        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_en    <= w_en_nxt;
            r_para  <= w_para_nxt;
            r_feat  <= w_feat_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;

            if (w_start_ok) begin
                r_weight_cnt  <= '0;
                r_feature_cnt <= '0;
            end else if ((r_state == S_W_STREAM) && w_beat) begin
                r_weight_cnt <= w_weight_inc;
            end else if ((r_state == S_F_STREAM) && w_beat) begin
                r_feature_cnt <= w_feature_inc;
            end

            r_gap <= (r_state == S_SWITCH) ? r_gap + 1'b1 : '0;

            // Idle-cycle count restarts on every beat and on any state change.
            if (!w_in_stream || w_beat || (w_nxt != r_state)) begin
                r_wd <= '0;
            end else begin
                r_wd <= r_wd + 1'b1;
            end
        end
    end

    // The latched totals only matter from start acceptance onward.
    always_ff @(posedge clk) begin
        if (w_start_ok) begin
            r_weight_num  <= cfg_weight_num;
            r_feature_num <= cfg_feature_num;
        end
    end

    assign en               = r_en;
    assign dma_read_para    = r_para;
    assign dma_read_feature = r_feat;
    assign busy             = r_busy;
    assign done             = r_done;
    assign err              = r_err;
    assign weight_cnt       = r_weight_cnt;
    assign feature_cnt      = r_feature_cnt;

endmodule
